pc_gen: RTL

//  Parametrised program-counter generator; successor to the fixed +4 PC.

---
 rtl/pc_gen_pkg.sv | 25 ++
 rtl/pc_gen_if.sv | 24 ++
 rtl/pc_gen_next_mux.sv | 54 +++++
 rtl/pc_gen.sv | 94 +++++++++
 4 files changed

// File: rtl/pc_gen_pkg.sv
// Shared types and helpers for the program-counter generator.
// The optional misaligned-target trap is selected by the PC_MISALIGN_CHECK_EN macro.
package pc_gen_pkg;

  // FSM states. BOOT lasts one cycle after reset. RUN issues fetches. HALT waits for a redirect.
  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } pc_state_t;

  // Source of the next PC value.
  typedef enum logic [1:0] {
    SEL_HOLD = 2'd0,
    SEL_INC  = 2'd1,
    SEL_BR   = 2'd2,
    SEL_JMP  = 2'd3
  } pc_sel_t;

  // Number of always-zero low address bits for a given instruction size in bytes.
  function automatic int inc_shift(input int ilen_bytes);
    return $clog2(ilen_bytes);
  endfunction

endpackage

// File: rtl/pc_gen_if.sv
// Fetch command bus between the PC generator (master) and instruction memory (slave).
// Handshake: a transfer happens on a rising clk edge where cmd_valid and cmd_ready are both high.
// While cmd_valid is high and cmd_ready is low, the master holds cmd_address stable.
// The exception is a branch/jump redirect, which replaces the address and drops the un-accepted
// request. cmd_ready may depend on cmd_valid. cmd_valid never depends on cmd_ready.
interface pc_gen_if #(
  parameter int XLEN = 32
) ();
  logic            cmd_valid;
  logic            cmd_ready;
  logic [XLEN-1:0] cmd_address;

  modport master (
    output cmd_valid,
    output cmd_address,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_address,
    output cmd_ready
  );
endinterface

// File: rtl/pc_gen_next_mux.sv
// Combinational next-PC select: hold, sequential increment, or redirect target.
// A redirect target is checked for alignment to the instruction size.
// With PC_MISALIGN_CHECK_EN defined, a misaligned target selects TRAP_VECTOR and flags it.
// Otherwise the target's low bits are cleared and no error is flagged.
module pc_next_mux
  import pc_gen_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter int              ILEN_BYTES  = 4,
  parameter logic [XLEN-1:0] TRAP_VECTOR = XLEN'(32'h0000_0100)
) (
  input  pc_sel_t         sel,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] br_target,
  input  logic [XLEN-1:0] jmp_target,
  output logic [XLEN-1:0] next_pc,
  output logic            misalign
);

  localparam int              SHIFT    = inc_shift(ILEN_BYTES);
  localparam logic [XLEN-1:0] INC      = XLEN'(ILEN_BYTES);
  localparam logic [XLEN-1:0] LOW_MASK = INC - XLEN'(1);

`ifdef PC_MISALIGN_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  logic [XLEN-1:0] target;
  logic            low_nz;

  // Pick the redirect source, then the next PC according to the select.
  always_comb begin
    target   = (sel == SEL_JMP) ? jmp_target : br_target;
    low_nz   = |target[SHIFT-1:0];
    next_pc  = pc;
    misalign = 1'b0;
    unique case (sel)
      SEL_INC:  next_pc = pc + INC;
      SEL_BR,
      SEL_JMP: begin
        if (CHECK_EN && low_nz) begin
          next_pc  = TRAP_VECTOR;
          misalign = 1'b1;
        end else begin
          next_pc  = target & ~LOW_MASK;
        end
      end
      default:  next_pc = pc;
    endcase
  end

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator. It holds the fetch address and advances it on an accepted fetch.
// It takes branch/jump redirects and honours stall and halt.
// It drives a valid/ready fetch request to instruction memory over pc_gen_if.
// Optional misaligned-redirect trap: define PC_MISALIGN_CHECK_EN.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter int              ILEN_BYTES   = 4,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100)
) (
  input  logic            clk,
  input  logic            a_reset_n,
  input  logic            stall,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_target,
  input  logic            jmp_valid,
  input  logic [XLEN-1:0] jmp_target,
  input  logic            halt_req,
  pc_gen_if.master        cmd,
  output logic            halted,
  output logic            misalign_err,
  output pc_state_t       state_dbg
);

  pc_state_t       state, next_state;
  pc_sel_t         sel;
  logic [XLEN-1:0] pc_q, next_pc;
  logic            mis_d, mis_q;
  logic            redirect;

  assign redirect = jmp_valid | br_taken;

  // Next state and next-PC source. Priority is jump > branch > stall > handshake > hold.
  // BOOT ignores all requests for its single cycle.
  always_comb begin
    next_state = state;
    sel        = SEL_HOLD;
    unique case (state)
      ST_BOOT: next_state = ST_RUN;
      ST_RUN: begin
        if (jmp_valid)           sel = SEL_JMP;
        else if (br_taken)       sel = SEL_BR;
        else if (stall)          sel = SEL_HOLD;
        else if (cmd.cmd_ready)  sel = SEL_INC;
        if (halt_req && !redirect) next_state = ST_HALT;
      end
      ST_HALT: begin
        if (jmp_valid) begin
          sel        = SEL_JMP;
          next_state = ST_RUN;
        end else if (br_taken) begin
          sel        = SEL_BR;
          next_state = ST_RUN;
        end
      end
      default: next_state = ST_BOOT;
    endcase
  end

  pc_next_mux #(
    .XLEN        (XLEN),
    .ILEN_BYTES  (ILEN_BYTES),
    .TRAP_VECTOR (TRAP_VECTOR)
  ) u_next_mux (
    .sel        (sel),
    .pc         (pc_q),
    .br_target  (br_target),
    .jmp_target (jmp_target),
    .next_pc    (next_pc),
    .misalign   (mis_d)
  );

  // State, PC and misalign pulse registers. Reset aborts any transaction immediately.
  always_ff @(posedge clk or negedge a_reset_n) begin
    if (!a_reset_n) begin
      state <= ST_BOOT;
      pc_q  <= RESET_VECTOR;
      mis_q <= 1'b0;
    end else begin
      state <= next_state;
      pc_q  <= next_pc;
      mis_q <= mis_d;
    end
  end

  assign cmd.cmd_valid   = (state == ST_RUN) & ~stall;
  assign cmd.cmd_address = pc_q;
  assign halted          = (state == ST_HALT);
  assign misalign_err    = mis_q;
  assign state_dbg       = state;

endmodule
